// File: rtl/gradient_magnitude_pipe.sv
// Three-stage gradient magnitude pipeline: |g|>>SHIFT, sum of squares, quantize with saturation.
// Define GRADIENT_MAGNITUDE_EDGE_FLAG_EN to add the thresh input and registered edge_flag output.
module gradient_magnitude_pipe #(
   parameter int GW    = 10,
   parameter int PW    = 4,
   parameter int SHIFT = 4,
   parameter int STEP  = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [GW-1:0] gx,
   input  logic [GW-1:0] gy,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [PW-1:0] pixel,
   output logic          out_valid,
`ifdef GRADIENT_MAGNITUDE_EDGE_FLAG_EN
   input  logic [PW-1:0] thresh,
   output logic          edge_flag,
`endif
   input  logic          out_ready
);

   localparam int AW   = GW - SHIFT;
   localparam int SW   = 2 * AW + 1;
   localparam int MAXP = (2 ** PW) - 1;

   logic          en;
   logic          s1_valid;
   logic [AW-1:0] s1_ax;
   logic [AW-1:0] s1_ay;
   logic          s2_valid;
   logic [SW-1:0] s2_sum;
   logic [SW-1:0] quot;
   logic [PW-1:0] pixel_next;

   // Magnitude is formed unsigned in GW bits so the most negative input maps to 2^(GW-1).
   function automatic logic [AW-1:0] abs_shift(input logic [GW-1:0] g);
      logic [GW-1:0] m;
      m = g[GW-1] ? (~g + 1'b1) : g;
      return m[GW-1:SHIFT];
   endfunction

   assign en       = !(out_valid && !out_ready);
   assign in_ready = en && !rst;

   always_comb begin
      quot       = s2_sum / SW'(STEP);
      pixel_next = quot[PW-1:0];
      if (quot > SW'(MAXP)) begin
         pixel_next = {PW{1'b1}};
      end
   end

   // Bubbles advance as invalid stages; pixel only loads when a real sample reaches S3.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_ax     <= '0;
         s1_ay     <= '0;
         s2_valid  <= 1'b0;
         s2_sum    <= '0;
         out_valid <= 1'b0;
         pixel     <= '0;
      end else if (en) begin
         s1_valid  <= in_valid;
         s1_ax     <= abs_shift(gx);
         s1_ay     <= abs_shift(gy);
         s2_valid  <= s1_valid;
         s2_sum    <= SW'(s1_ax) * SW'(s1_ax) + SW'(s1_ay) * SW'(s1_ay);
         out_valid <= s2_valid;
         if (s2_valid) begin
            pixel <= pixel_next;
         end
      end
   end

`ifdef GRADIENT_MAGNITUDE_EDGE_FLAG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         edge_flag <= 1'b0;
      end else if (en && s2_valid) begin
         edge_flag <= (pixel_next >= thresh);
      end
   end
`endif

endmodule

// File: tb/tb_gradient_magnitude_pipe.sv
// Self-checking bench for gradient_magnitude_pipe: directed cases plus randomized traffic
// scored against an arithmetic reference model and an in-order expectation queue.
module tb_gradient_magnitude_pipe;

   localparam int GW    = 10;
   localparam int PW    = 4;
   localparam int SHIFT = 4;
   localparam int STEP  = 3;

   logic          tb_clk = 1'b0;
   logic          rst = 1'b1;
   logic [GW-1:0] gx = '0;
   logic [GW-1:0] gy = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [PW-1:0] pixel;
   logic          out_valid;
   logic          out_ready = 1'b1;
`ifdef GRADIENT_MAGNITUDE_EDGE_FLAG_EN
   logic [PW-1:0] thresh = '0;
   logic          edge_flag;
`endif

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int delivered = 0;
   int model_pixel = 0;
   int exp_q[$];
   logic accepted;

   always #5 tb_clk = ~tb_clk;

   gradient_magnitude_pipe #(.GW(GW), .PW(PW), .SHIFT(SHIFT), .STEP(STEP)) dut (
      .clk(tb_clk),
      .rst(rst),
      .gx(gx),
      .gy(gy),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .pixel(pixel),
      .out_valid(out_valid),
`ifdef GRADIENT_MAGNITUDE_EDGE_FLAG_EN
      .thresh(thresh),
      .edge_flag(edge_flag),
`endif
      .out_ready(out_ready)
   );

   function automatic int model_pix(int x, int y);
      int ax, ay, s, q;
      ax = (x < 0 ? -x : x) / (2 ** SHIFT);
      ay = (y < 0 ? -y : y) / (2 ** SHIFT);
      s  = ax * ax + ay * ay;
      q  = s / STEP;
      return (q > (2 ** PW) - 1) ? (2 ** PW) - 1 : q;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // One clock cycle: drive before the edge, observe 1 time unit later, update the scoreboard.
   task automatic applyStimulus(input logic v, input int x, input int y, input logic ordy, input logic r);
      @(negedge tb_clk);
      rst       = r;
      in_valid  = v;
      gx        = GW'(x);
      gy        = GW'(y);
      out_ready = ordy;
      #1;
      accepted = 1'b0;
      if (r) begin
         checkOutput("in_ready_during_reset", in_ready, 0);
         exp_q.delete();
         model_pixel = 0;
      end else begin
         if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checkOutput("spurious_out_valid", out_valid, 0);
            end else begin
               checkOutput("pixel_vs_model", pixel, exp_q[0]);
               if (ordy) begin
                  model_pixel = exp_q.pop_front();
                  delivered++;
               end
            end
         end else begin
            checkOutput("pixel_hold", pixel, model_pixel);
         end
         if (v && in_ready === 1'b1) begin
            exp_q.push_back(model_pix(x, y));
            accepted = 1'b1;
         end
      end
      cycle++;
   endtask

   task automatic runSingle(input int x, input int y, input int exp_pix, input string tag, input logic check_lat);
      int   lat;
      logic seen;
      lat  = 0;
      seen = 1'b0;
      applyStimulus(1'b1, x, y, 1'b1, 1'b0);
      checkOutput({tag, "_accepted"}, accepted, 1);
      for (int i = 0; i < 10 && !seen; i++) begin
         applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
         lat++;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      checkOutput({tag, "_out_seen"}, seen, 1);
      checkOutput({tag, "_pixel"}, pixel, exp_pix);
      if (check_lat) checkOutput({tag, "_latency"}, lat, 3);
   endtask

   int bp_x[5] = '{64, 20, -48, 40, 100};
   int bp_y[5] = '{64, -20, 32, 0, -60};

   initial begin
      int idx;
      int d0;
      $display("[TB] starting");

      applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_pixel", pixel, 0);
      checkOutput("reset_in_ready", in_ready, 1);

      runSingle(64, 64, 10, "base", 1'b1);
      runSingle(150, 150, 15, "sat_150", 1'b0);
      runSingle(-512, -512, 15, "sat_min", 1'b0);
      runSingle(-150, 0, 15, "sat_81", 1'b0);
      runSingle(20, -20, 0, "trunc_2", 1'b0);
      runSingle(-48, 32, 4, "trunc_13", 1'b0);

`ifdef GRADIENT_MAGNITUDE_EDGE_FLAG_EN
      thresh = 4'd10;
      runSingle(64, 64, 10, "edge_t10", 1'b0);
      checkOutput("edge_t10_flag", edge_flag, 1);
      thresh = 4'd11;
      runSingle(64, 64, 10, "edge_t11", 1'b0);
      checkOutput("edge_t11_flag", edge_flag, 0);
      thresh = 4'd0;
`endif

      // Backpressure: five samples offered back to back, downstream stalls cycles 4-6.
      idx = 0;
      d0  = delivered;
      for (int c = 0; c < 20; c++) begin
         applyStimulus(idx < 5, (idx < 5) ? bp_x[idx] : 0, (idx < 5) ? bp_y[idx] : 0,
                       !(c >= 4 && c <= 6), 1'b0);
         if (accepted) idx++;
         if (c >= 4 && c <= 6) checkOutput("bp_in_ready_low", in_ready, 0);
      end
      checkOutput("bp_all_accepted", idx, 5);
      checkOutput("bp_all_delivered", delivered - d0, 5);

      // Mid-stream reset with two samples in flight.
      applyStimulus(1'b1, 64, 64, 1'b1, 1'b0);
      applyStimulus(1'b1, 150, 150, 1'b1, 1'b0);
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
      checkOutput("midrst_out_valid", out_valid, 0);
      checkOutput("midrst_pixel", pixel, 0);
      checkOutput("midrst_in_ready", in_ready, 1);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);

      // Random traffic with random valid and ready patterns.
      for (int i = 0; i < 400; i++) begin
         int x, y;
         if ($urandom_range(0, 1) == 0) begin
            x = int'($urandom_range(0, 1023)) - 512;
            y = int'($urandom_range(0, 1023)) - 512;
         end else begin
            x = int'($urandom_range(0, 200)) - 100;
            y = int'($urandom_range(0, 200)) - 100;
         end
         applyStimulus($urandom_range(0, 9) < 7, x, y, $urandom_range(0, 9) < 6, 1'b0);
      end

      for (int i = 0; i < 30 && exp_q.size() != 0; i++) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
      checkOutput("drain_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
